// File: rtl/ysyx_22040895_wb_stage_pkg.sv
// Shared definitions for the writeback stage: reset/write polarities, bus types,
// RV64 load funct3 encodings, the ebreak encoding and the stage FSM states.
package ysyx_22040895_wb_stage_pkg;

    localparam int XLEN_DEF    = 64;
    localparam int RADDR_W_DEF = 5;

    localparam logic RST_ENABLE    = 1'b1;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef logic [XLEN_DEF-1:0]    reg_bus_t;
    typedef logic [RADDR_W_DEF-1:0] reg_addr_bus_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/ysyx_22040895_wb_stage_load_ext.sv
// Load-data extraction: picks the addressed lane from an aligned doubleword,
// sign-/zero-extends it, and flags misaligned or undefined load types.
module ysyx_22040895_load_ext
    import ysyx_22040895_wb_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      addr_lo_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o,
    output logic            fault_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        data_o  = '0;
        fault_o = 1'b0;
        case (funct3_i)
            F3_LB:  data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LBU: data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LH: begin
                data_o  = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
                fault_o = addr_lo_i[0];
            end
            F3_LHU: begin
                data_o  = {{(XLEN-16){1'b0}}, shifted[15:0]};
                fault_o = addr_lo_i[0];
            end
            F3_LW: begin
                data_o  = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
                fault_o = (addr_lo_i[1:0] != 2'b00);
            end
            F3_LWU: begin
                data_o  = {{(XLEN-32){1'b0}}, shifted[31:0]};
                fault_o = (addr_lo_i[1:0] != 2'b00);
            end
            F3_LD: begin
                data_o  = shifted;
                fault_o = (addr_lo_i != 3'b000);
            end
            default: fault_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx_22040895_wb_stage.sv
// Writeback stage: registers one MEM record per cycle, commits it to the regfile
// the next cycle, counts retired instructions and halts after ebreak.
// Optional difftest trace outputs: define YSYX_22040895_COMMIT_TRACE_EN.
module ysyx_22040895_wb_stage
    import ysyx_22040895_wb_stage_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [63:0]        in_pc_i,
    input  logic [31:0]        in_inst_i,
    input  logic [RADDR_W-1:0] in_rd_i,
    input  logic               in_rd_we_i,
    input  logic               in_is_load_i,
    input  logic [2:0]         in_ld_funct3_i,
    input  logic [2:0]         in_addr_lo_i,
    input  logic [XLEN-1:0]    in_alu_res_i,
    input  logic [XLEN-1:0]    in_mem_rdata_i,
    input  logic               hold_i,
    output logic               we_o,
    output logic [RADDR_W-1:0] waddr_o,
    output logic [XLEN-1:0]    wdata_o,
    output logic               fwd_valid_o,
    output logic [RADDR_W-1:0] fwd_rd_o,
    output logic [XLEN-1:0]    fwd_data_o,
    output logic               ld_fault_o,
    output logic [63:0]        instret_o,
    output logic               halt_o,
    output logic               dbg_state_o
`ifdef YSYX_22040895_COMMIT_TRACE_EN
    ,
    output logic               commit_valid_o,
    output logic [63:0]        commit_pc_o,
    output logic [31:0]        commit_inst_o
`endif
);

    wb_state_e          state_q, state_d;
    logic               valid_q, valid_d;
    logic [RADDR_W-1:0] rd_q, rd_d;
    logic               rd_we_q, rd_we_d;
    logic               is_load_q, is_load_d;
    logic [2:0]         ld_funct3_q, ld_funct3_d;
    logic [2:0]         addr_lo_q, addr_lo_d;
    logic [XLEN-1:0]    alu_res_q, alu_res_d;
    logic [XLEN-1:0]    mem_rdata_q, mem_rdata_d;
    logic               is_ebreak_q, is_ebreak_d;
    logic [63:0]        instret_q, instret_d;
`ifdef YSYX_22040895_COMMIT_TRACE_EN
    logic [63:0]        pc_q, pc_d;
    logic [31:0]        inst_q, inst_d;
`endif

    logic               accept;
    logic [XLEN-1:0]    ext_data;
    logic               ext_fault;
    logic               fault;

    ysyx_22040895_load_ext #(.XLEN(XLEN)) u_load_ext (
        .rdata_i   (mem_rdata_q),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (ld_funct3_q),
        .data_o    (ext_data),
        .fault_o   (ext_fault)
    );

    // Handshake: a record transfers on a rising edge where in_valid_i && in_ready_o.
    // in_ready_o never depends on in_valid_i; the producer must hold its record until taken.
    assign in_ready_o = (state_q == ST_RUN) && !hold_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        valid_d     = accept;
        rd_d        = rd_q;
        rd_we_d     = rd_we_q;
        is_load_d   = is_load_q;
        ld_funct3_d = ld_funct3_q;
        addr_lo_d   = addr_lo_q;
        alu_res_d   = alu_res_q;
        mem_rdata_d = mem_rdata_q;
        is_ebreak_d = is_ebreak_q;
`ifdef YSYX_22040895_COMMIT_TRACE_EN
        pc_d        = pc_q;
        inst_d      = inst_q;
`endif
        if (accept) begin
            rd_d        = in_rd_i;
            rd_we_d     = in_rd_we_i;
            is_load_d   = in_is_load_i;
            ld_funct3_d = in_ld_funct3_i;
            addr_lo_d   = in_addr_lo_i;
            alu_res_d   = in_alu_res_i;
            mem_rdata_d = in_mem_rdata_i;
            // Only the ebreak flag is needed for halting, so the full word is kept only for tracing.
            is_ebreak_d = (in_inst_i == EBREAK_INST);
`ifdef YSYX_22040895_COMMIT_TRACE_EN
            pc_d        = in_pc_i;
            inst_d      = in_inst_i;
`endif
        end

        instret_d = valid_q ? instret_q + 64'd1 : instret_q;

        state_d = state_q;
        if (state_q == ST_RUN && valid_q && is_ebreak_q) begin
            state_d = ST_HALT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q     <= ST_RUN;
            valid_q     <= 1'b0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            is_load_q   <= 1'b0;
            ld_funct3_q <= '0;
            addr_lo_q   <= '0;
            alu_res_q   <= '0;
            mem_rdata_q <= '0;
            is_ebreak_q <= 1'b0;
            instret_q   <= '0;
`ifdef YSYX_22040895_COMMIT_TRACE_EN
            pc_q        <= '0;
            inst_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            rd_we_q     <= rd_we_d;
            is_load_q   <= is_load_d;
            ld_funct3_q <= ld_funct3_d;
            addr_lo_q   <= addr_lo_d;
            alu_res_q   <= alu_res_d;
            mem_rdata_q <= mem_rdata_d;
            is_ebreak_q <= is_ebreak_d;
            instret_q   <= instret_d;
`ifdef YSYX_22040895_COMMIT_TRACE_EN
            pc_q        <= pc_d;
            inst_q      <= inst_d;
`endif
        end
    end

    // Fault only matters for a live load; a stale stage register must not pulse it.
    assign fault = valid_q && is_load_q && ext_fault;

    assign we_o    = (valid_q && rd_we_q && (rd_q != '0) && !fault) ? WRITE_ENABLE : WRITE_DISABLE;
    assign waddr_o = rd_q;
    assign wdata_o = is_load_q ? ext_data : alu_res_q;

    assign fwd_valid_o = we_o;
    assign fwd_rd_o    = waddr_o;
    assign fwd_data_o  = wdata_o;

    assign ld_fault_o  = fault;
    assign instret_o   = instret_q;
    assign halt_o      = (state_q == ST_HALT);
    assign dbg_state_o = state_q;

`ifdef YSYX_22040895_COMMIT_TRACE_EN
    assign commit_valid_o = valid_q;
    assign commit_pc_o    = pc_q;
    assign commit_inst_o  = inst_q;
`endif

endmodule

// File: tb/tb_ysyx_22040895_wb_stage.sv
// Directed bench for the writeback stage: a driver issues MEM records and queues
// the expected commit; a negedge monitor pops and compares each commit.
module tb_ysyx_22040895_wb_stage;
  import ysyx_22040895_wb_stage_pkg::*;

  localparam int EW = 71;  // {fault, we, waddr[4:0], wdata[63:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [63:0] in_pc_i = '0;
  logic [31:0] in_inst_i = '0;
  logic [4:0]  in_rd_i = '0;
  logic        in_rd_we_i = 1'b0;
  logic        in_is_load_i = 1'b0;
  logic [2:0]  in_ld_funct3_i = '0;
  logic [2:0]  in_addr_lo_i = '0;
  logic [63:0] in_alu_res_i = '0;
  logic [63:0] in_mem_rdata_i = '0;
  logic        hold_i = 1'b0;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [63:0] wdata_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_rd_o;
  logic [63:0] fwd_data_o;
  logic        ld_fault_o;
  logic [63:0] instret_o;
  logic        halt_o;
  logic        dbg_state_o;
`ifdef YSYX_22040895_COMMIT_TRACE_EN
  logic        commit_valid_o;
  logic [63:0] commit_pc_o;
  logic [31:0] commit_inst_o;
`endif

  ysyx_22040895_wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_pc_i        (in_pc_i),
    .in_inst_i      (in_inst_i),
    .in_rd_i        (in_rd_i),
    .in_rd_we_i     (in_rd_we_i),
    .in_is_load_i   (in_is_load_i),
    .in_ld_funct3_i (in_ld_funct3_i),
    .in_addr_lo_i   (in_addr_lo_i),
    .in_alu_res_i   (in_alu_res_i),
    .in_mem_rdata_i (in_mem_rdata_i),
    .hold_i         (hold_i),
    .we_o           (we_o),
    .waddr_o        (waddr_o),
    .wdata_o        (wdata_o),
    .fwd_valid_o    (fwd_valid_o),
    .fwd_rd_o       (fwd_rd_o),
    .fwd_data_o     (fwd_data_o),
    .ld_fault_o     (ld_fault_o),
    .instret_o      (instret_o),
    .halt_o         (halt_o),
    .dbg_state_o    (dbg_state_o)
`ifdef YSYX_22040895_COMMIT_TRACE_EN
    ,
    .commit_valid_o (commit_valid_o),
    .commit_pc_o    (commit_pc_o),
    .commit_inst_o  (commit_inst_o)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [63:0]   exp_instret = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] mk_exp(input logic fault, input logic we,
                                           input logic [4:0] waddr, input logic [63:0] wdata);
    return {fault, we, waddr, wdata};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_rec(input logic [4:0] rd, input logic rd_we, input logic is_load,
                           input logic [2:0] f3, input logic [2:0] alo,
                           input logic [63:0] alu, input logic [63:0] rdata,
                           input logic [31:0] inst);
    in_rd_i        = rd;
    in_rd_we_i     = rd_we;
    in_is_load_i   = is_load;
    in_ld_funct3_i = f3;
    in_addr_lo_i   = alo;
    in_alu_res_i   = alu;
    in_mem_rdata_i = rdata;
    in_inst_i      = inst;
    in_pc_i        = 64'h8000_0000 + 64'($urandom_range(0, 255)) * 4;
    in_valid_i     = 1'b1;
  endtask

  task automatic wait_accept(input logic [EW-1:0] exp);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready_o) begin
        exp_q.push_back(exp);
        done = 1;
      end else begin
        n++;
        if (n > 50) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept_timeout: in_ready_o stayed 0 for %0d cycles", n);
          done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic send(input logic [4:0] rd, input logic rd_we, input logic is_load,
                      input logic [2:0] f3, input logic [2:0] alo,
                      input logic [63:0] alu, input logic [63:0] rdata,
                      input logic [31:0] inst, input logic [EW-1:0] exp);
    drive_rec(rd, rd_we, is_load, f3, alo, alu, rdata, inst);
    wait_accept(exp);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic cap_pend;
    logic [EW-1:0] e;
    cap_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cap_pend = 1'b0;
        exp_instret = '0;
        exp_q.delete();
      end else begin
        check("instret", instret_o, exp_instret);
        if (cap_pend) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL commit_unexpected: commit with empty expected queue at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("ld_fault", 64'(ld_fault_o), 64'(e[70]));
            check("we", 64'(we_o), 64'(e[69]));
            check("fwd_valid", 64'(fwd_valid_o), 64'(e[69]));
            if (e[69]) begin
              check("waddr", 64'(waddr_o), 64'(e[68:64]));
              check("wdata", wdata_o, e[63:0]);
              check("fwd_rd", 64'(fwd_rd_o), 64'(e[68:64]));
              check("fwd_data", fwd_data_o, e[63:0]);
            end
          end
          exp_instret = exp_instret + 64'd1;
        end else begin
          check("idle_we", 64'(we_o), 64'd0);
          check("idle_fault", 64'(ld_fault_o), 64'd0);
        end
        cap_pend = in_valid_i && in_ready_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin : stimulus
    #1;
    check("rst_we", 64'(we_o), 64'd0);
    check("rst_waddr", 64'(waddr_o), 64'd0);
    check("rst_wdata", wdata_o, 64'd0);
    check("rst_fault", 64'(ld_fault_o), 64'd0);
    check("rst_halt", 64'(halt_o), 64'd0);
    check("rst_instret", instret_o, 64'd0);
    check("rst_state", 64'(dbg_state_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // non-load ALU write
    send(5'd5, 1, 0, F3_LB, 3'd0, 64'h1234, 64'h0, NOP,
         mk_exp(0, 1, 5'd5, 64'h1234));
    // lb / lbu lane 3
    send(5'd6, 1, 1, F3_LB, 3'd3, 64'h0, 64'h0000_0000_8000_0000, NOP,
         mk_exp(0, 1, 5'd6, 64'hFFFF_FFFF_FFFF_FF80));
    send(5'd7, 1, 1, F3_LBU, 3'd3, 64'h0, 64'h0000_0000_8000_0000, NOP,
         mk_exp(0, 1, 5'd7, 64'h80));
    // misaligned lw: fault, no write
    send(5'd8, 1, 1, F3_LW, 3'd2, 64'h0, 64'h1111_2222_3333_4444, NOP,
         mk_exp(1, 0, 5'd8, 64'h0));
    // x0 write suppressed
    send(5'd0, 1, 0, F3_LB, 3'd0, 64'hDEAD, 64'h0, NOP,
         mk_exp(0, 0, 5'd0, 64'h0));
    // lh / lhu lane 2
    send(5'd9, 1, 1, F3_LH, 3'd2, 64'h0, 64'h0000_0000_8001_0000, NOP,
         mk_exp(0, 1, 5'd9, 64'hFFFF_FFFF_FFFF_8001));
    send(5'd10, 1, 1, F3_LHU, 3'd2, 64'h0, 64'h0000_0000_8001_0000, NOP,
         mk_exp(0, 1, 5'd10, 64'h8001));
    // ld aligned
    send(5'd11, 1, 1, F3_LD, 3'd0, 64'h0, 64'h0123_4567_89AB_CDEF, NOP,
         mk_exp(0, 1, 5'd11, 64'h0123_4567_89AB_CDEF));
    // lw / lwu upper word
    send(5'd12, 1, 1, F3_LW, 3'd4, 64'h0, 64'hDEAD_BEEF_0000_0000, NOP,
         mk_exp(0, 1, 5'd12, 64'hFFFF_FFFF_DEAD_BEEF));
    send(5'd13, 1, 1, F3_LWU, 3'd4, 64'h0, 64'hDEAD_BEEF_0000_0000, NOP,
         mk_exp(0, 1, 5'd13, 64'hDEAD_BEEF));
    // illegal funct3, misaligned ld, misaligned lh
    send(5'd14, 1, 1, 3'b111, 3'd0, 64'h0, 64'h55, NOP, mk_exp(1, 0, 5'd14, 64'h0));
    send(5'd15, 1, 1, F3_LD, 3'd4, 64'h0, 64'h55, NOP, mk_exp(1, 0, 5'd15, 64'h0));
    send(5'd16, 1, 1, F3_LH, 3'd1, 64'h0, 64'h55, NOP, mk_exp(1, 0, 5'd16, 64'h0));
    // rd_we=0
    send(5'd17, 0, 0, F3_LB, 3'd0, 64'h77, 64'h0, NOP, mk_exp(0, 0, 5'd17, 64'h0));

    // hold: the staged record commits once, nothing new is taken for 3 cycles
    send(5'd18, 1, 0, F3_LB, 3'd0, 64'hA5A5, 64'h0, NOP, mk_exp(0, 1, 5'd18, 64'hA5A5));
    hold_i = 1'b1;
    drive_rec(5'd19, 1, 0, F3_LB, 3'd0, 64'h5A5A, 64'h0, NOP);
    repeat (3) begin
      @(negedge clk);
      check("hold_ready", 64'(in_ready_o), 64'd0);
    end
    @(posedge clk);
    #1;
    hold_i = 1'b0;
    wait_accept(mk_exp(0, 1, 5'd19, 64'h5A5A));

    // ebreak, followed by a record taken during the ebreak commit cycle
    send(5'd0, 0, 0, F3_LB, 3'd0, 64'h0, 64'h0, EBREAK_INST, mk_exp(0, 0, 5'd0, 64'h0));
    send(5'd20, 1, 0, F3_LB, 3'd0, 64'h2020, 64'h0, NOP, mk_exp(0, 1, 5'd20, 64'h2020));
    drive_rec(5'd21, 1, 0, F3_LB, 3'd0, 64'h2121, 64'h0, NOP);
    repeat (4) begin
      @(negedge clk);
      check("halt", 64'(halt_o), 64'd1);
      check("halt_ready", 64'(in_ready_o), 64'd0);
      check("halt_state", 64'(dbg_state_o), 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;

    // asynchronous reset mid-cycle clears halt and instret at once
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_halt", 64'(halt_o), 64'd0);
    check("async_rst_instret", instret_o, 64'd0);
    check("async_rst_we", 64'(we_o), 64'd0);
    check("async_rst_ready", 64'(in_ready_o), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // stage runs again after reset
    send(5'd22, 1, 0, F3_LB, 3'd0, 64'hABCD, 64'h0, NOP, mk_exp(0, 1, 5'd22, 64'hABCD));
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
